pll_reset_enable_gen: RTL and testbench

Sits directly downstream of the system PLL. It consumes the PLL's asynchronous locked flag and the 57.272728 MHz core clock, and produces a clean synchronous core reset plus the single-cycle clock-enable strobes that drive the Atari core:
- colour clock: 3.579545 MHz, clk/16
- CPU cycle: 1.789773 MHz, clk/32, with turbo options.
All downstream logic runs on clk and is qualified by these enables; no derived clocks.

---
 rtl/atari_clk_pkg.sv | 30 +++
 rtl/sync_bit.sv | 23 ++
 rtl/pll_reset_enable_gen.sv | 115 +++++++++++
 tb/tb_pll_reset_enable_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/atari_clk_pkg.sv
// rtl/atari_clk_pkg.sv - shared states, turbo encodings and divider constants for the core clock enables
package atari_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int PHASE_W      = 5;
  localparam int COLOUR_DIV   = 16;
  localparam int CPU_DIV_BASE = 32;

  localparam logic [1:0] TURBO_X1 = 2'd0;
  localparam logic [1:0] TURBO_X2 = 2'd1;
  localparam logic [1:0] TURBO_X4 = 2'd2;
  localparam logic [1:0] TURBO_X8 = 2'd3;

  // Low phase bits that must all be ones for a CPU strobe at the given turbo setting.
  function automatic logic [PHASE_W-1:0] cpu_mask(input logic [1:0] turbo_sel);
    case (turbo_sel)
      TURBO_X1: cpu_mask = PHASE_W'(CPU_DIV_BASE - 1);
      TURBO_X2: cpu_mask = PHASE_W'(CPU_DIV_BASE / 2 - 1);
      TURBO_X4: cpu_mask = PHASE_W'(CPU_DIV_BASE / 4 - 1);
      TURBO_X8: cpu_mask = PHASE_W'(CPU_DIV_BASE / 8 - 1);
      default:  cpu_mask = PHASE_W'(CPU_DIV_BASE - 1);
    endcase
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-stage single-bit synchroniser with synchronous clear
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_enable_gen.sv
// rtl/pll_reset_enable_gen.sv - PLL-lock qualified core reset plus colour/CPU clock-enable strobes
module pll_reset_enable_gen
  import atari_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int HOLD_W      = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic [1:0]         turbo,
  output logic               core_reset,
  output logic               ce_colour,
  output logic               ce_cpu,
  output logic [PHASE_W-1:0] phase,
  output logic               running
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic lk_s;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [1:0]          turbo_act_q, turbo_act_d;
  logic                core_reset_q, core_reset_d;
  logic                running_q, running_d;
  logic                ce_colour_q, ce_colour_d;
  logic                ce_cpu_q, ce_cpu_d;
  logic                run_now, run_next;
  logic [PHASE_W-1:0]  cpu_sel;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i(clk),
    .clr_i(reset),
    .d_i  (pll_locked),
    .q_o  (lk_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lk_s) state_d = HOLD;
      HOLD: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     if (!lk_s) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    run_now     = (state_q == RUN);
    run_next    = (state_d == RUN);
    cpu_sel     = cpu_mask(turbo_act_q);
    hold_cnt_d  = '0;
    if (state_q == HOLD && state_d == HOLD) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    phase_d     = (run_now && run_next) ? phase_q + 1'b1 : '0;
    // Rate changes land only on a full wrap so no CPU cycle is ever cut short.
    turbo_act_d = turbo_act_q;
    if (run_next && (!run_now || phase_q == '1)) begin
      turbo_act_d = turbo;
    end
    core_reset_d = !run_next;
    running_d    = run_next;
    ce_colour_d  = run_now && run_next && (phase_q[3:0] == 4'(COLOUR_DIV - 1));
    ce_cpu_d     = run_now && run_next && ((phase_q & cpu_sel) == cpu_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q   <= '0;
      phase_q      <= '0;
      turbo_act_q  <= TURBO_X1;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      ce_colour_q  <= 1'b0;
      ce_cpu_q     <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      phase_q      <= phase_d;
      turbo_act_q  <= turbo_act_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      ce_colour_q  <= ce_colour_d;
      ce_cpu_q     <= ce_cpu_d;
    end
  end

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign phase      = phase_q;
  assign ce_colour  = ce_colour_q;
  assign ce_cpu     = ce_cpu_q;

endmodule

// File: tb/tb_pll_reset_enable_gen.sv
// tb/tb_pll_reset_enable_gen.sv - directed plus randomized bench with a lock-streak reference model
module tb_pll_reset_enable_gen;

  localparam int SYNC = 2;
  localparam int HOLD = 8;
  localparam int LAT  = SYNC + 1 + HOLD;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic [1:0] turbo;
  logic       core_reset, ce_colour, ce_cpu, running;
  logic [4:0] phase;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  bit dl [SYNC];
  int streak, m_phase, m_tact;
  bit m_run, m_cec, m_cecpu;

  pll_reset_enable_gen #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .HOLD_W     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .turbo     (turbo),
    .core_reset(core_reset),
    .ce_colour (ce_colour),
    .ce_cpu    (ce_cpu),
    .phase     (phase),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: the core runs once the synchronised lock has been seen high on HOLD+1 consecutive edges.
  task automatic step();
    bit lk, prev_run;
    int ph_old, ta_old, div;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < SYNC; i++) dl[i] = 1'b0;
      streak = 0; m_run = 0; m_phase = 0; m_tact = 0; m_cec = 0; m_cecpu = 0;
    end else begin
      lk = dl[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = pll_locked;
      prev_run = m_run;
      ph_old = m_phase;
      ta_old = m_tact;
      streak = lk ? ((streak < 1000000) ? streak + 1 : streak) : 0;
      m_run = (streak > HOLD);
      div = 32 >> ta_old;
      m_cec   = prev_run && m_run && (ph_old % 16 == 15);
      m_cecpu = prev_run && m_run && (ph_old % div == div - 1);
      if (!m_run) begin
        m_phase = 0;
      end else if (!prev_run) begin
        m_phase = 0;
        m_tact = turbo;
      end else begin
        m_phase = (ph_old + 1) % 32;
        if (ph_old == 31) m_tact = turbo;
      end
    end
    @(negedge clk);
    cyc++;
    chk("core_reset", core_reset, !m_run);
    chk("running", running, m_run);
    chk("phase", phase, m_phase);
    chk("ce_colour", ce_colour, m_cec);
    chk("ce_cpu", ce_cpu, m_cecpu);
  endtask

  initial begin
    int n, last_c, last_p, nc, drop;
    reset = 1'b1; pll_locked = 1'b0; turbo = 2'd0;
    for (int i = 0; i < 5; i++) step();
    chk("reset_core_reset", core_reset, 1);
    chk("reset_strobes", {ce_colour, ce_cpu, running}, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();

    pll_locked = 1'b1;
    n = 0;
    while (core_reset !== 1'b0 && n < 60) begin step(); n++; end
    chk("powerup_latency", n, LAT);

    last_c = -1; last_p = -1; nc = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (ce_colour === 1'b1) begin
        if (last_c >= 0) chk("colour_gap", cyc - last_c, 16);
        last_c = cyc; nc++;
      end
      if (ce_cpu === 1'b1) begin
        if (last_p >= 0) chk("cpu_gap", cyc - last_p, 32);
        chk("cpu_on_colour", ce_colour, 1);
        last_p = cyc;
      end
    end
    chk("colour_seen", nc >= 4, 1);

    n = 0;
    while (phase !== 5'd10 && n < 64) begin step(); n++; end
    chk("reach_phase10", phase, 10);
    turbo = 2'd3;
    n = 0;
    while (ce_cpu !== 1'b1 && n < 40) begin step(); n++; end
    chk("old_period_kept", n, 22);
    chk("cpu_at_wrap_phase", phase, 0);
    n = 0;
    do begin step(); n++; end while (ce_cpu !== 1'b1 && n < 10);
    chk("turbo3_gap", n, 4);
    for (int i = 0; i < 40; i++) step();

    pll_locked = 1'b0;
    n = 0;
    while (core_reset !== 1'b1 && n < 10) begin step(); n++; end
    chk("loss_latency", n, SYNC + 1);
    chk("loss_phase", phase, 0);
    chk("loss_strobes", {ce_colour, ce_cpu}, 0);
    for (int i = 0; i < 4; i++) step();

    pll_locked = 1'b1;
    for (int i = 0; i < 6; i++) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 0;
    while (core_reset !== 1'b0 && n < 60) begin step(); n++; end
    chk("glitch_relock_latency", n, LAT);

    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    step();
    chk("midrun_reset_core_reset", core_reset, 1);
    chk("midrun_reset_running", running, 0);
    reset = 1'b0;
    n = 0;
    while (core_reset !== 1'b0 && n < 60) begin step(); n++; end
    chk("post_reset_latency", n, LAT);

    drop = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) turbo = 2'($urandom_range(0, 3));
      if (drop > 0) begin
        drop--;
        if (drop == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        pll_locked = 1'b0;
        drop = $urandom_range(1, 12);
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
